// File: rtl/config_uart_tx.sv
// config_uart_tx: 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Status and readback bytes from the fabric config logic are queued here and
// shifted out to the host at BAUD_RATE. The line register tx_reg follows the
// FSM state by one cycle. As a result, a push into an empty idle block shows
// up as a falling edge on tx_o two cycles later. It also means back-to-back
// frames abut with no idle bit between them.
module config_uart_tx #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_system_i,
    input  logic                          reset_n_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO: pointers carry one extra bit so full and empty differ.
    // ------------------------------------------------------------------
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    logic [7:0]     head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    state_t         state_reg;
    state_t         state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]     shift_reg;
    logic [7:0]     shift_next;
    logic [2:0]     bit_idx_reg;
    logic [2:0]     bit_idx_next;
    logic           tx_reg;
    logic           tx_next;
    logic           line_active_reg;

    assign level_o = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level_o == FULL_LEVEL);
    assign empty   = (level_o == '0);
    assign head    = mem[rd_ptr_reg[PTR_W-1:0]];

    // A full FIFO still accepts a byte in the cycle the FSM pops the head.
    // Advertising that slot through ready_o keeps the handshake honest: the
    // producer sees exactly the beats that were taken. pop depends only on
    // registered state, so ready_o has no path from valid_i.
    assign ready_o = ~full | pop;
    assign push    = valid_i & ready_o;

    // Storage array; only the write port is clocked, the head is read by the FSM load.
    always_ff @(posedge clk_system_i) begin
        if (push) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= data_i;
        end
    end

    // FIFO pointers; both wrap naturally through the extra MSB.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W + 1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_W + 1)'(1);
            end
        end
    end

    // Next-state, baud counter, shifter and the line value for the next cycle.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        pop          = 1'b0;
        tx_next      = 1'b1;

        unique case (state_reg)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (!empty) begin
                    pop          = 1'b1;
                    shift_next   = head;
                    bit_idx_next = 3'd0;
                    state_next   = START;
                end
            end

            START: begin
                tx_next = 1'b0;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DATA;
                end
            end

            DATA: begin
                tx_next = shift_reg[0];
                if (cnt_reg == CNT_LAST) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = {1'b0, shift_reg[7:1]};
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end

            STOP: begin
                tx_next = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    // Chain straight into the next frame when a byte is waiting.
                    if (!empty) begin
                        pop          = 1'b1;
                        shift_next   = head;
                        bit_idx_next = 3'd0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // FSM, shifter and line registers; reset forces the line high immediately.
    always_ff @(posedge clk_system_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            shift_reg       <= '0;
            bit_idx_reg     <= '0;
            tx_reg          <= 1'b1;
            line_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            shift_reg       <= shift_next;
            bit_idx_reg     <= bit_idx_next;
            tx_reg          <= tx_next;
            line_active_reg <= (state_reg != IDLE);
        end
    end

    assign tx_o = tx_reg;

    // line_active_reg covers the final stop-bit cycle still on the wire after the
    // FSM has returned to IDLE. busy_o therefore spans the whole frame as seen on tx_o.
    assign busy_o = (state_reg != IDLE) | ~empty | line_active_reg;

endmodule

// File: tb/tb_config_uart_tx.sv
// tb_config_uart_tx: directed and randomized checks of config_uart_tx.
// A behavioural UART receiver decodes tx_o, and its output is compared with
// the bytes the producer handed over.
module tb_config_uart_tx;

    localparam int CLK_FREQ   = 400;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = CLK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * CPB;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          valid = 1'b0;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         frame_err = 0;

    always #5 clk = ~clk;

    config_uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_system_i(clk),
        .reset_n_i   (rst_n),
        .data_i      (data),
        .valid_i     (valid),
        .ready_o     (ready),
        .tx_o        (tx),
        .busy_o      (busy),
        .level_o     (level)
    );

    // Reference receiver: finds a start bit, samples each bit one cycle into its cell.
    initial begin : rx_model
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                @(negedge clk);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    // Global time limit.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // Present a byte at the current negedge; hold it until accepted or max_wait expires.
    task automatic push_byte(input logic [7:0] b, input int max_wait, output bit ok);
        ok    = 1'b0;
        valid = 1'b1;
        data  = b;
        for (int w = 0; w < max_wait; w++) begin
            if (ready) begin
                ok = 1'b1;
                exp_q.push_back(b);
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    // Wait for the transmitter to go quiet, then let the receiver model settle.
    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < max_cycles; w++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic flush_queues();
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ready !== 1'b1)    begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (level !== LW'(0))  begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: tx=%b busy=%b want tx=1 busy=0", tx, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        bit         ok;
        logic [9:0] fr;
        logic [7:0] b = 8'hA5;
        flush_queues();
        fr = {1'b1, b, 1'b0};
        push_byte(b, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: byte not accepted, want accepted"); end
        checks++; if (tx !== 1'b1 || level !== LW'(1) || busy !== 1'b1) begin
            errors++; $display("FAIL single_c1: tx=%b level=%0d busy=%b want 1/1/1", tx, level, busy);
        end
        @(negedge clk);
        checks++; if (tx !== 1'b1 || level !== LW'(0)) begin
            errors++; $display("FAIL single_c2: tx=%b level=%0d want tx=1 level=0", tx, level);
        end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++; if (tx !== fr[k / CPB]) begin
                errors++; $display("FAIL single_bit: cycle %0d tx=%b want %b", k, tx, fr[k / CPB]);
            end
            checks++; if (busy !== 1'b1) begin
                errors++; $display("FAIL single_busy: cycle %0d busy=%b want 1", k, busy);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL single_end: busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
        repeat (3) @(negedge clk);
        checks++; if (rx_q.size() != 1 || rx_q[0] !== b) begin
            errors++; $display("FAIL single_rx: got %0d bytes first=%h want 1 byte a5", rx_q.size(),
                               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        $display("test_single_frame done: byte a5");
    endtask

    task automatic test_back_to_back();
        bit         ok;
        bit         found;
        logic [7:0] bytes [3];
        logic [9:0] fr;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        flush_queues();
        for (int i = 0; i < 3; i++) begin
            push_byte(bytes[i], 4, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept: byte %0d not accepted", i); end
        end
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            if (tx === 1'b0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL b2b_start: no start bit within 10 cycles"); end
        for (int k = 0; k < 3 * FRAME; k++) begin
            fr = {1'b1, bytes[k / FRAME], 1'b0};
            checks++; if (tx !== fr[(k % FRAME) / CPB]) begin
                errors++; $display("FAIL b2b_bit: cycle %0d tx=%b want %b", k, tx, fr[(k % FRAME) / CPB]);
            end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL b2b_end: busy=%b tx=%b want busy=0 tx=1", busy, tx);
        end
        repeat (3) @(negedge clk);
        checks++; if (rx_q.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d bytes want 3", rx_q.size());
        end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== bytes[i]) begin
                errors++; $display("FAIL b2b_byte: index %0d got %h want %h", i, rx_q[i], bytes[i]);
            end
        end
        $display("test_back_to_back done: 00 ff 3c");
    endtask

    task automatic test_fifo_full();
        logic [7:0] bytes [6];
        int         idx = 0;
        int         max_level = 0;
        bit         seen_full = 1'b0;
        logic       full_ready = 1'bx;
        bit         ok;
        flush_queues();
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        valid = 1'b1;
        for (int w = 0; w < 400 && idx < 6; w++) begin
            data = bytes[idx];
            if (int'(level) > max_level) max_level = int'(level);
            if (level == LW'(FIFO_DEPTH) && !seen_full) begin
                seen_full  = 1'b1;
                full_ready = ready;
            end
            if (ready) begin
                exp_q.push_back(bytes[idx]);
                idx++;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++; if (idx != 6) begin errors++; $display("FAIL full_accept: accepted %0d want 6", idx); end
        checks++; if (!seen_full) begin errors++; $display("FAIL full_reached: level never hit %0d", FIFO_DEPTH); end
        checks++; if (full_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready: ready=%b at first full want 0", full_ready);
        end
        checks++; if (max_level != FIFO_DEPTH) begin
            errors++; $display("FAIL full_max: max level %0d want %0d", max_level, FIFO_DEPTH);
        end
        wait_idle(8 * FRAME, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_idle: busy did not drop"); end
        checks++; if (rx_q.size() != 6) begin
            errors++; $display("FAIL full_count: got %0d bytes want 6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_byte: index %0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        $display("test_fifo_full done: %0d bytes", idx);
    endtask

    task automatic test_full_push_pop();
        bit         ok;
        bit         taken = 1'b0;
        logic [7:0] extra;
        logic [LW-1:0] lvl_before = '0;
        flush_queues();
        for (int i = 0; i < 5; i++) begin
            push_byte(8'($urandom), 4, ok);
            checks++; if (!ok) begin errors++; $display("FAIL pp_fill: byte %0d not accepted", i); end
        end
        checks++; if (level !== LW'(FIFO_DEPTH) || ready !== 1'b0) begin
            errors++; $display("FAIL pp_full: level=%0d ready=%b want %0d/0", level, ready, FIFO_DEPTH);
        end
        extra = 8'($urandom);
        valid = 1'b1;
        data  = extra;
        for (int w = 0; w < 2 * FRAME; w++) begin
            if (ready) begin
                lvl_before = level;
                exp_q.push_back(extra);
                taken = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        checks++; if (!taken) begin errors++; $display("FAIL pp_accept: extra byte never accepted"); end
        checks++; if (lvl_before !== LW'(FIFO_DEPTH) || level !== LW'(FIFO_DEPTH)) begin
            errors++; $display("FAIL pp_level: before=%0d after=%0d want %0d/%0d",
                               lvl_before, level, FIFO_DEPTH, FIFO_DEPTH);
        end
        wait_idle(8 * FRAME, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pp_idle: busy did not drop"); end
        checks++; if (rx_q.size() != 6) begin
            errors++; $display("FAIL pp_count: got %0d bytes want 6", rx_q.size());
        end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL pp_byte: index %0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        $display("test_full_push_pop done: extra byte %h", extra);
    endtask

    task automatic test_reset_mid_frame();
        bit         ok;
        bit         found = 1'b0;
        logic [7:0] b;
        checks++; if (frame_err != 0) begin
            errors++; $display("FAIL rst_prior_framing: %0d framing errors want 0", frame_err);
        end
        flush_queues();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom), 4, ok);
        for (int w = 0; w < 10; w++) begin
            if (tx === 1'b0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_start: no start bit seen"); end
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
        checks++; if (level !== LW'(0) || busy !== 1'b0 || ready !== 1'b1) begin
            errors++; $display("FAIL rst_state: level=%0d busy=%b ready=%b want 0/0/1", level, busy, ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        flush_queues();
        frame_err = 0;
        b = 8'($urandom);
        push_byte(b, 4, ok);
        wait_idle(2 * FRAME, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_idle: busy did not drop"); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== b || frame_err != 0) begin
            errors++; $display("FAIL rst_next: got %0d bytes first=%h ferr=%0d want 1 byte %h ferr 0",
                               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, frame_err, b);
        end
        $display("test_reset_mid_frame done: post-reset byte %h", b);
    endtask

    task automatic test_random();
        bit ok;
        int timeouts = 0;
        int gap;
        flush_queues();
        for (int n = 0; n < 200; n++) begin
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            push_byte(8'($urandom), 8 * FRAME, ok);
            if (!ok) timeouts++;
        end
        checks++; if (timeouts != 0) begin
            errors++; $display("FAIL rand_accept: %0d pushes timed out want 0", timeouts);
        end
        wait_idle(8 * FRAME, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_idle: busy did not drop"); end
        checks++; if (rx_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_byte: index %0d got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
        checks++; if (frame_err != 0) begin
            errors++; $display("FAIL rand_framing: %0d framing errors want 0", frame_err);
        end
        $display("test_random done: %0d bytes sent, %0d decoded", exp_q.size(), rx_q.size());
    endtask

    initial begin : main
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_full_push_pop();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
